// File: rtl/edge_gen_pkg.sv
// edge_gen_pkg: shared types and sizing helper for the edge generator
package edge_gen_pkg;
    typedef enum logic [1:0] {LOW, HIGH, LOW_HOLD, HIGH_HOLD} state_t;
    typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL} edge_t;
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction
endpackage

// File: rtl/edge_generator_hold_timer.sv
// hold_timer: loadable down-counter that stops at zero and flags expiry
module hold_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    assign expired = (cnt_q == '0);
endmodule

// File: rtl/edge_generator.sv
// edge_generator: turns rise/fall request pulses into a level with minimum high/low times
module edge_generator
    import edge_gen_pkg::*;
#(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic rise_req,
    input  logic fall_req,
    output logic signal,
    output logic rise,
    output logic fall,
    output logic busy
);
    localparam int CW = cnt_width(MIN_HIGH, MIN_LOW);
    state_t          state_q, state_d;
    edge_t           pend_q, pend_d, req, decision;
    logic            signal_q, signal_d, rise_q, rise_d, fall_q, fall_d, busy_q, busy_d;
    logic            load, expired;
    logic [CW-1:0]   load_val;
    hold_timer #(.WIDTH(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );
    always_comb begin
        req      = (rise_req && !fall_req) ? EDGE_RISE : (fall_req && !rise_req) ? EDGE_FALL : EDGE_NONE;
        decision = (req != EDGE_NONE) ? req : pend_q;
        state_d  = state_q;
        pend_d   = pend_q;
        load     = 1'b0;
        load_val = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state_q)
            LOW: if (req == EDGE_RISE) begin
                state_d  = HIGH_HOLD;
                load     = 1'b1;
                load_val = CW'(MIN_HIGH - 1);
                rise_d   = 1'b1;
            end
            HIGH: if (req == EDGE_FALL) begin
                state_d  = LOW_HOLD;
                load     = 1'b1;
                load_val = CW'(MIN_LOW - 1);
                fall_d   = 1'b1;
            end
            HIGH_HOLD: if (!expired) begin
                pend_d = (req == EDGE_FALL) ? EDGE_FALL : (req == EDGE_RISE) ? EDGE_NONE : pend_q;
            end else begin
                pend_d   = EDGE_NONE;
                state_d  = (decision == EDGE_FALL) ? LOW_HOLD : HIGH;
                load     = (decision == EDGE_FALL);
                load_val = CW'(MIN_LOW - 1);
                fall_d   = (decision == EDGE_FALL);
            end
            LOW_HOLD: if (!expired) begin
                pend_d = (req == EDGE_RISE) ? EDGE_RISE : (req == EDGE_FALL) ? EDGE_NONE : pend_q;
            end else begin
                pend_d   = EDGE_NONE;
                state_d  = (decision == EDGE_RISE) ? HIGH_HOLD : LOW;
                load     = (decision == EDGE_RISE);
                load_val = CW'(MIN_HIGH - 1);
                rise_d   = (decision == EDGE_RISE);
            end
            default: state_d = LOW;
        endcase
        signal_d = (state_d == HIGH) || (state_d == HIGH_HOLD);
        busy_d   = (state_d == HIGH_HOLD) || (state_d == LOW_HOLD);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= LOW;
            pend_q   <= EDGE_NONE;
            signal_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            signal_q <= signal_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    assign signal = signal_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_edge_generator.sv
// tb_edge_generator: directed vectors with a scoreboard of expected {signal,rise,fall,busy}
module tb_edge_generator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rise_req = 1'b0;
    logic fall_req = 1'b0;
    logic signal, rise, fall, busy;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    typedef struct {
        bit       r;
        bit       f;
        bit [3:0] e;
    } vec_t;
    vec_t     stim[$];
    bit [3:0] sb[$];

    edge_generator #(.MIN_HIGH(4), .MIN_LOW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .rise_req (rise_req),
        .fall_req (fall_req),
        .signal   (signal),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit [3:0] act, input bit [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {sig,rise,fall,busy}=%b expected %b", name, act, exp);
        end
    endtask

    // monitor: one output sample per cycle, compared against the oldest expectation
    always @(negedge clk)
        if (sb.size() != 0) begin
            check($sformatf("vec%0d", cyc), {signal, rise, fall, busy}, sb.pop_front());
            cyc++;
        end

    function automatic void v(input bit r, input bit f, input bit [3:0] e);
        stim.push_back('{r: r, f: f, e: e});
    endfunction

    task automatic play();
        while (stim.size() != 0) begin
            vec_t x;
            x = stim.pop_front();
            @(posedge clk);
            #1;
            rise_req = x.r;
            fall_req = x.f;
            sb.push_back(x.e);
        end
        @(negedge clk);
        #1;
        rise_req = 1'b0;
        fall_req = 1'b0;
    endtask

    initial begin
        #3;
        check("reset_hold", {signal, rise, fall, busy}, 4'b0000);
        #9 rst = 1'b0;
        // rise from idle, hold, then fall from HIGH
        v(1,0,4'b0000); v(0,0,4'b1101); v(0,0,4'b1001); v(0,0,4'b1001); v(0,0,4'b1001);
        v(0,0,4'b1000); v(0,1,4'b1000); v(0,0,4'b0011); v(0,0,4'b0001); v(0,0,4'b0001);
        v(0,0,4'b0000);
        // deferred fall
        v(1,0,4'b0000); v(0,0,4'b1101); v(0,1,4'b1001); v(0,0,4'b1001); v(0,0,4'b1001);
        v(0,0,4'b0011); v(0,0,4'b0001); v(0,0,4'b0001); v(0,0,4'b0000);
        // cancelled pending fall, then rise on the low-hold expiry cycle
        v(1,0,4'b0000); v(0,0,4'b1101); v(0,1,4'b1001); v(1,0,4'b1001); v(0,0,4'b1001);
        v(0,0,4'b1000); v(0,0,4'b1000); v(0,1,4'b1000); v(0,0,4'b0011); v(0,0,4'b0001);
        v(1,0,4'b0001); v(0,0,4'b1101); v(0,0,4'b1001); v(0,0,4'b1001); v(0,0,4'b1001);
        v(0,1,4'b1000); v(0,0,4'b0011); v(0,0,4'b0001); v(0,0,4'b0001); v(0,0,4'b0000);
        // simultaneous requests ignored
        v(1,1,4'b0000); v(0,0,4'b0000); v(0,0,4'b0000);
        // deferred rise in low hold, then a pending rise cancelled by a fall
        v(1,0,4'b0000); v(0,0,4'b1101); v(0,1,4'b1001); v(0,0,4'b1001); v(0,0,4'b1001);
        v(0,0,4'b0011); v(1,0,4'b0001); v(0,0,4'b0001); v(0,0,4'b1101); v(0,0,4'b1001);
        v(0,0,4'b1001); v(0,0,4'b1001); v(0,1,4'b1000); v(0,0,4'b0011); v(1,0,4'b0001);
        v(0,1,4'b0001); v(0,0,4'b0000); v(0,0,4'b0000); v(0,0,4'b0000);
        // reset mid-hold with a pending fall
        v(1,0,4'b0000); v(0,1,4'b1101); v(0,0,4'b1001);
        play();
        #1 rst = 1'b1;
        #1;
        check("async_rst", {signal, rise, fall, busy}, 4'b0000);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("post_rst", {signal, rise, fall, busy}, 4'b0000);
        v(0,0,4'b0000); v(1,0,4'b0000); v(0,0,4'b1101); v(0,0,4'b1001); v(0,0,4'b1001);
        play();
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
